uart_tx_framer: RTL
===================

# uart_tx_framer

Byte-serial UART transmitter that sits directly downstream of the push-button synchronizer/one-shot. A single-cycle `send` pulse (the one-shot output) captures `data_in` and emits one 8N1 frame on `tx`. A one-entry holding register absorbs a second request that arrives mid-frame. Any request beyond that is dropped and flagged.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `DATA_BITS`, default 8: payload width; LSB is sent first.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high. The clock is `clk`.
- `send` input 1: single-cycle request pulse, driven by the button one-shot output.
- `data_in` input DATA_BITS: payload, sampled in the cycle `send`=1.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high while a frame is in flight or the holding register is full.
- `done` output 1: one-cycle pulse in the last cycle of each stop bit.
- `overrun` output 1: one-cycle pulse when a `send` is dropped.

## Operation
- `CLKS_PER_BIT` = CLK_FREQ / BAUD, using integer floor. With the defaults this is 10416. It must be ≥2; this is checked at elaboration.
- Frame layout: start bit (0), then DATA_BITS data bits LSB-first, then one stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
- IDLE, with `send`=1: load the shift register from `data_in` and go to START.
- START: when the bit counter expires, go to DATA with bit index 0.
- DATA: shift one bit each time the counter expires. After bit DATA_BITS-1, go to STOP.
- STOP, on counter expiry:
  - if the holding register is valid, move its contents to the shift register, clear it, and go to START;
  - otherwise go to IDLE.
- `send` while not in IDLE:
  - if the holding register is empty, store `data_in` in it;
  - if it is full, keep the held data, drop the new byte, and pulse `overrun`.
- Simultaneous events:
  - `send` in the last STOP cycle with the holding register full: the held byte starts its frame and the new byte fills the freed holding slot. This is not an overrun.
  - `send` in IDLE always goes straight to START, never to the holding register.
- `busy` = (state≠IDLE) OR hold_valid.
- Reset values: `tx`=1, `busy`=0, `done`=0, `overrun`=0, state IDLE, hold_valid=0, counters 0.
- Reset mid-frame abandons the frame. `tx` returns to 1 on the edge after reset is asserted. The held byte is discarded.

## Timing
- Request to line: `send` sampled at edge N in IDLE gives `tx`=0 and `busy`=1 from edge N+1.
- Frame length: 10·CLKS_PER_BIT cycles for DATA_BITS=8.
  - The start bit occupies cycles N+1 … N+CLKS_PER_BIT.
  - Data bit k starts at N+1+(k+1)·CLKS_PER_BIT.
- `done` is high in the final stop-bit cycle only.
- Back-to-back frames: when the holding register is valid, the next start bit begins on the cycle immediately after the stop bit. There is no idle gap.
- `tx` is registered, so no combinational path exists from any input to `tx`.
- `overrun` is asserted in the cycle after the dropped `send`.

## Structure
- Package `uart_pkg` contains:
  - `tx_state_t` enum {IDLE, START, DATA, STOP} in `logic [1:0]`;
  - function `clks_per_bit(CLK_FREQ, BAUD)`;
  - constants for the start-bit level (0) and stop-bit level (1). The future receiver shares these.
- Sub-module `uart_baud_gen`:
  - cycle counter that pulses `bit_tick` every CLKS_PER_BIT cycles;
  - restarts on a `restart` input asserted at frame start;
  - width is $clog2(CLKS_PER_BIT).
- The top level contains the FSM, the bit index counter ($clog2(DATA_BITS)), the shift register and the holding register.

## Test plan
Test parameters: CLK_FREQ=16, BAUD=4, so CLKS_PER_BIT=4 and a frame is 40 cycles.
- Reset, then idle for 20 cycles: `tx`=1, `busy`=0, `done`=0, `overrun`=0 throughout.
- `send` with `data_in`=8'hA5:
  - `tx` holds 0 for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1, 4 cycles each;
  - then 1 for 4 cycles;
  - `done` in cycle 40;
  - `busy` drops on the next cycle.
- `send` 8'h3C, then `send` 8'hC3 ten cycles later:
  - two contiguous frames, 80 cycles, with no idle gap;
  - one `done` per frame;
  - no `overrun`.
- Three `send` pulses (8'h01, 8'h02, 8'h03) within the first frame: frames for 01 and 02 are sent; `overrun` pulses exactly once, on the third request.
- `send` 8'h55 with holding full, in the last STOP cycle of frame 1:
  - the held byte is transmitted next, then 8'h55;
  - no `overrun`.
- Reset asserted at cycle 17 of a frame:
  - `tx`=1 and `busy`=0 from the next edge;
  - a `send` after reset produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, line levels and baud arithmetic.
// The receiver will import the same line levels.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int clks_per_bit(int clk_freq, int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last cycle of every CLKS_PER_BIT-cycle bit.
// While restart is high the count is held at zero, so a new frame gets a full first bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last   = (r_cnt == LAST);
    assign bit_tick = w_last && !restart;

    always_ff @(posedge clk) begin
        if (reset || restart || w_last) r_cnt <= '0;
        else                            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// 8N1-style UART transmitter fed by single-cycle send pulses, with a one-entry
// holding slot for a request that arrives mid-frame; further requests are dropped.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_shifted;
    logic [DATA_BITS-1:0] r_hold, w_hold_nxt;
    logic                 r_hold_vld, w_hold_vld_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_ovr, w_ovr_nxt;
    logic                 w_tick, w_restart, w_frame_end;

    assign w_restart   = (r_state == IDLE);
    assign w_frame_end = (r_state == STOP) && w_tick;
    assign w_shifted   = r_shift >> 1;

    uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (w_restart),
        .bit_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_idx      <= '0;
            r_tx       <= STOP_BIT;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_vld <= w_hold_vld_nxt;
            r_idx      <= w_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_ovr      <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_hold_nxt     = r_hold;
        w_hold_vld_nxt = r_hold_vld;
        w_idx_nxt      = r_idx;
        w_tx_nxt       = r_tx;
        w_ovr_nxt      = 1'b0;

        case (r_state)
            IDLE: if (send) begin
                w_shift_nxt = data_in;
                w_tx_nxt    = START_BIT;
                w_state_nxt = START;
            end
            START: if (w_tick) begin
                w_tx_nxt    = r_shift[0];
                w_idx_nxt   = '0;
                w_state_nxt = DATA;
            end
            DATA: if (w_tick) begin
                if (r_idx == LAST_IDX) begin
                    w_tx_nxt    = STOP_BIT;
                    w_state_nxt = STOP;
                end else begin
                    w_shift_nxt = w_shifted;
                    w_tx_nxt    = w_shifted[0];
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            STOP: if (w_tick) begin
                // A request landing on the final stop cycle with an empty slot starts directly.
                if (r_hold_vld) begin
                    w_shift_nxt    = r_hold;
                    w_hold_vld_nxt = 1'b0;
                    w_tx_nxt       = START_BIT;
                    w_state_nxt    = START;
                end else if (send) begin
                    w_shift_nxt = data_in;
                    w_tx_nxt    = START_BIT;
                    w_state_nxt = START;
                end else begin
                    w_tx_nxt    = STOP_BIT;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (send && (r_state != IDLE)) begin
            if (w_frame_end && r_hold_vld) begin
                w_hold_nxt     = data_in;
                w_hold_vld_nxt = 1'b1;
            end else if (!w_frame_end && !r_hold_vld) begin
                w_hold_nxt     = data_in;
                w_hold_vld_nxt = 1'b1;
            end else if (!w_frame_end) begin
                w_ovr_nxt = 1'b1;
            end
        end
    end

    assign tx      = r_tx;
    assign busy    = (r_state != IDLE) || r_hold_vld;
    assign done    = w_frame_end;
    assign overrun = r_ovr;

endmodule
